mem_arbiter: RTL

- Shares the single data RAM port (daddr/MemWrite/MemRead/ddata_w/ddata_r) between two requesters.
- Requester 0 is the core data port. Requester 1 is the loader/debug port that preloads and inspects memory.
- Round-robin arbitration, registered memory command, and in-order routing of read data back to the issuing requester.
- Sits between the cores/bench drivers and ram. Accepts one request per cycle.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_rr.sv | 45 ++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-requester RAM arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LATENCY = 3;

  typedef enum logic {
    REQ_CORE   = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic req_id_t other_req(req_id_t k);
    return (k == REQ_CORE) ? REQ_LOADER : REQ_CORE;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker; the loser of a grant is favoured next
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_t prio_q, prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (prio_q == REQ_LOADER) ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = other_req(REQ_CORE);
    end else if (gnt_o[1]) begin
      prio_d = other_req(REQ_LOADER);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= REQ_CORE;
    end else if (clear_i) begin
      prio_q <= REQ_CORE;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between core and loader with in-order read return
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0] wdata0,
  input  logic [DATA_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_SIZE-1:0] rdata0,
  output logic [DATA_SIZE-1:0] rdata1,
  output logic [ADDR_SIZE-1:0] daddr,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [DATA_SIZE-1:0] ddata_w,
  input  logic [DATA_SIZE-1:0] ddata_r
);

  // One tag per cycle between accept and the RAM data being valid.
  localparam int TAG_STAGES = RD_LATENCY - 1;

  logic [1:0] rr_gnt;

  mem_arb_rr u_rr (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .clear_i  (CLEAR),
    .enable_i (~CLEAR),
    .req_i    ({req1, req0}),
    .gnt_o    (rr_gnt)
  );

  // Reset gating is applied only to the outputs so no flop sees RESET_N as data.
  assign gnt0 = rr_gnt[0] & RESET_N;
  assign gnt1 = rr_gnt[1] & RESET_N;

  logic                 accept;
  req_id_t              sel_id;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;

  always_comb begin
    accept    = |rr_gnt;
    sel_id    = rr_gnt[1] ? REQ_LOADER : REQ_CORE;
    sel_we    = rr_gnt[1] ? we1 : we0;
    sel_addr  = rr_gnt[1] ? addr1 : addr0;
    sel_wdata = rr_gnt[1] ? wdata1 : wdata0;
  end

  logic [ADDR_SIZE-1:0] daddr_q, daddr_d;
  logic [DATA_SIZE-1:0] ddata_w_q, ddata_w_d;
  logic                 mem_write_q, mem_write_d;
  logic                 mem_read_q, mem_read_d;

  always_comb begin
    daddr_d     = daddr_q;
    ddata_w_d   = ddata_w_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    if (CLEAR) begin
      daddr_d   = '0;
      ddata_w_d = '0;
    end else if (accept) begin
      daddr_d     = sel_addr;
      ddata_w_d   = sel_wdata;
      mem_write_d = sel_we;
      mem_read_d  = ~sel_we;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      daddr_q     <= '0;
      ddata_w_q   <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      daddr_q     <= daddr_d;
      ddata_w_q   <= ddata_w_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign daddr    = daddr_q;
  assign ddata_w  = ddata_w_q;
  assign MemWrite = mem_write_q;
  assign MemRead  = mem_read_q;

  tag_t [TAG_STAGES-1:0] tag_q, tag_d;
  tag_t                  tag_tail;

  always_comb begin
    tag_d = '0;
    if (!CLEAR) begin
      tag_d[0].valid = accept & ~sel_we;
      tag_d[0].id    = sel_id;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_tail = tag_q[TAG_STAGES-1];

  logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  always_comb begin
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (CLEAR) begin
      rdata0_d = '0;
      rdata1_d = '0;
    end else if (tag_tail.valid) begin
      if (tag_tail.id == REQ_CORE) begin
        rvalid0_d = 1'b1;
        rdata0_d  = ddata_r;
      end else begin
        rvalid1_d = 1'b1;
        rdata1_d  = ddata_r;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
